// File: rtl/branch_compare_pipe.sv
// -----------------------------------------------------------------------------
// branch_compare_pipe
//
// Pipelined magnitude comparator and branch-condition resolver for the execute
// path. Two WIDTH-bit operands are compared CHUNK bits at a time, LSB-first,
// CPS chunks per stage, over NS = WIDTH/(CHUNK*CPS) register stages. The last
// stage applies the signed override, decodes funct3 into a taken flag, and
// registers the result that drives the output ports.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous kill of every in-flight entry
//   in_valid/in_ready  input handshake (in_ready is combinational from
//                      out_ready and flush; there is no skid buffer)
//   in_a, in_b         operands
//   in_funct3, in_tag  branch funct3 and opaque tag
//   out_valid/out_ready output handshake
//   out_less/equal/greater  compare result (signed or unsigned per funct3)
//   out_taken          branch condition true
//   out_illegal        funct3 is 010 or 011
//   out_tag            tag of this result
// -----------------------------------------------------------------------------
module branch_compare_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int CPS   = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_funct3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_less,
    output logic             out_equal,
    output logic             out_greater,
    output logic             out_taken,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Bits consumed per stage and number of stages.
    localparam int SW = CHUNK * CPS;
    localparam int NS = WIDTH / SW;

    // Flags are carried as {L, E, G}.
    function automatic logic [2:0] fold_slice(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic [2:0]    leg_in
    );
        logic             l;
        logic             e;
        logic             g;
        logic [CHUNK-1:0] ac;
        logic [CHUNK-1:0] bc;
        l = leg_in[2];
        e = leg_in[1];
        g = leg_in[0];
        // Higher chunks are folded later, so a difference there dominates.
        for (int i = 0; i < CPS; i++) begin
            ac = a[i*CHUNK +: CHUNK];
            bc = b[i*CHUNK +: CHUNK];
            l  = (ac < bc) | ((ac == bc) & l);
            g  = (ac > bc) | ((ac == bc) & g);
            e  = (ac == bc) & e;
        end
        return {l, e, g};
    endfunction

    // Returns {taken, illegal}.
    function automatic logic [1:0] decode_taken(
        input logic [2:0] f3,
        input logic       less,
        input logic       equal
    );
        logic [1:0] res;
        case (f3)
            3'b000:         res = {equal, 1'b0};
            3'b001:         res = {~equal, 1'b0};
            3'b100, 3'b110: res = {less, 1'b0};
            3'b101, 3'b111: res = {~less, 1'b0};
            3'b010, 3'b011: res = {1'b0, 1'b1};
            default:        res = {1'b0, 1'b1};
        endcase
        return res;
    endfunction

    logic [NS-1:0] valid_r;
    logic [NS-1:0] adv_s;        // stage k may take new contents this cycle
    logic [NS-1:0] src_valid_s;  // valid of whatever would enter stage k
    logic [NS-1:0] load_s;       // stage k captures a live entry this cycle
    logic          in_fire_s;

    assign in_ready  = ~flush & adv_s[0];
    assign in_fire_s = in_valid & in_ready;

    // Ready chain: a stage can refill if it is empty or its successor can.
    always_comb begin
        adv_s           = '0;
        src_valid_s     = '0;
        load_s          = '0;
        adv_s[NS-1]     = ~valid_r[NS-1] | out_ready;
        for (int k = NS - 2; k >= 0; k--) begin
            adv_s[k] = ~valid_r[k] | adv_s[k+1];
        end
        src_valid_s[0] = in_fire_s;
        for (int k = 1; k < NS; k++) begin
            src_valid_s[k] = valid_r[k-1];
        end
        for (int k = 0; k < NS; k++) begin
            load_s[k] = adv_s[k] & src_valid_s[k] & ~flush;
        end
    end

    // Valid bits; flush empties the pipe at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (adv_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NS; k++) begin : stg
        // Operand bits still to be consumed, from stage k's chunk upward. The
        // top bit of this window is always the operand MSB, so the MSBs ride
        // along with the unconsumed bits and need no separate register.
        localparam int SRC_W = WIDTH - k * SW;

        logic [SRC_W-1:0] src_a_s;
        logic [SRC_W-1:0] src_b_s;
        logic [2:0]       src_leg_s;
        logic [2:0]       src_f3_s;
        logic [TAG_W-1:0] src_tag_s;
        logic [2:0]       fold_s;

        if (k == 0) begin : g_src
            assign src_a_s   = in_a;
            assign src_b_s   = in_b;
            assign src_leg_s = 3'b010;
            assign src_f3_s  = in_funct3;
            assign src_tag_s = in_tag;
        end else begin : g_src
            assign src_a_s   = stg[k-1].g_mid.a_rem_r;
            assign src_b_s   = stg[k-1].g_mid.b_rem_r;
            assign src_leg_s = stg[k-1].g_mid.leg_r;
            assign src_f3_s  = stg[k-1].g_mid.f3_r;
            assign src_tag_s = stg[k-1].g_mid.tag_r;
        end

        assign fold_s = fold_slice(src_a_s[SW-1:0], src_b_s[SW-1:0], src_leg_s);

        if (k < NS - 1) begin : g_mid
            logic [SRC_W-SW-1:0] a_rem_r;
            logic [SRC_W-SW-1:0] b_rem_r;
            logic [2:0]          leg_r;
            logic [2:0]          f3_r;
            logic [TAG_W-1:0]    tag_r;

            // Intermediate stage payload: running flags and unconsumed bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_r <= '0;
                    b_rem_r <= '0;
                    leg_r   <= 3'b000;
                    f3_r    <= 3'b000;
                    tag_r   <= '0;
                end else if (load_s[k]) begin
                    a_rem_r <= src_a_s[SRC_W-1:SW];
                    b_rem_r <= src_b_s[SRC_W-1:SW];
                    leg_r   <= fold_s;
                    f3_r    <= src_f3_s;
                    tag_r   <= src_tag_s;
                end
            end
        end else begin : g_last
            logic             a_msb_s;
            logic             b_msb_s;
            logic             signed_s;
            logic             res_less_s;
            logic             res_equal_s;
            logic             res_greater_s;
            logic [1:0]       dec_s;
            logic             less_r;
            logic             equal_r;
            logic             greater_r;
            logic             taken_r;
            logic             illegal_r;
            logic [TAG_W-1:0] tag_r;

            assign a_msb_s = src_a_s[SRC_W-1];
            assign b_msb_s = src_b_s[SRC_W-1];
            // Only 11x is unsigned; the illegal 01x codes report signed.
            assign signed_s = ~(src_f3_s[2] & src_f3_s[1]);

            // Signed override on the folded magnitude flags, then decode.
            always_comb begin
                res_less_s    = fold_s[2];
                res_equal_s   = fold_s[1];
                res_greater_s = fold_s[0];
                if (signed_s) begin
                    res_less_s    = (a_msb_s & ~b_msb_s) | ((a_msb_s ~^ b_msb_s) & fold_s[2]);
                    res_greater_s = (~a_msb_s & b_msb_s) | ((a_msb_s ~^ b_msb_s) & fold_s[0]);
                end else begin
                    res_less_s    = fold_s[2];
                    res_greater_s = fold_s[0];
                end
                dec_s = decode_taken(src_f3_s, res_less_s, res_equal_s);
            end

            // Output register; holds while the consumer stalls.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    less_r    <= 1'b0;
                    equal_r   <= 1'b0;
                    greater_r <= 1'b0;
                    taken_r   <= 1'b0;
                    illegal_r <= 1'b0;
                    tag_r     <= '0;
                end else if (load_s[k]) begin
                    less_r    <= res_less_s;
                    equal_r   <= res_equal_s;
                    greater_r <= res_greater_s;
                    taken_r   <= dec_s[1];
                    illegal_r <= dec_s[0];
                    tag_r     <= src_tag_s;
                end
            end
        end
    end

    assign out_valid   = valid_r[NS-1];
    assign out_less    = stg[NS-1].g_last.less_r;
    assign out_equal   = stg[NS-1].g_last.equal_r;
    assign out_greater = stg[NS-1].g_last.greater_r;
    assign out_taken   = stg[NS-1].g_last.taken_r;
    assign out_illegal = stg[NS-1].g_last.illegal_r;
    assign out_tag     = stg[NS-1].g_last.tag_r;

endmodule

// File: tb/tb_branch_compare_pipe.sv
// -----------------------------------------------------------------------------
// Directed testbench for branch_compare_pipe (default parameters, NS = 4).
// -----------------------------------------------------------------------------
module tb_branch_compare_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_funct3;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_less;
    logic        out_equal;
    logic        out_greater;
    logic        out_taken;
    logic        out_illegal;
    logic [4:0]  out_tag;

    branch_compare_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_funct3  (in_funct3),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_less   (out_less),
        .out_equal  (out_equal),
        .out_greater(out_greater),
        .out_taken  (out_taken),
        .out_illegal(out_illegal),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- observation ----------------
    typedef struct {
        logic [4:0] tag;
        logic       l;
        logic       e;
        logic       g;
        logic       t;
        logic       i;
        int         lat;
    } obs_t;

    obs_t obs_q[$];
    int   cyc = 0;
    int   acc_cyc [32];
    int   last_seen [32] = '{default: -1};
    int   occ = 0;
    logic stall_hold = 1'b0;
    logic [9:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        obs_t o;
        if (!rst_n) begin
            occ        = 0;
            stall_hold = 1'b0;
        end else begin
            // Any empty slot or a draining output lets a beat in.
            chk("in_ready_model", in_ready, (!flush && (occ < 4 || out_ready)));
            if (stall_hold) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {out_tag, out_less, out_equal, out_greater, out_taken, out_illegal}, held);
            end
            if (out_valid) last_seen[out_tag] = cyc;
            if (out_valid && out_ready && !flush) begin
                o.tag = out_tag;
                o.l   = out_less;
                o.e   = out_equal;
                o.g   = out_greater;
                o.t   = out_taken;
                o.i   = out_illegal;
                o.lat = cyc - acc_cyc[out_tag];
                obs_q.push_back(o);
            end
            if (in_valid && in_ready) acc_cyc[in_tag] = cyc;
            if (flush) occ = 0;
            else occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            stall_hold = out_valid && !out_ready && !flush;
            held = {out_tag, out_less, out_equal, out_greater, out_taken, out_illegal};
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic [4:0] tag);
        int n;
        n         = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_funct3 = f3;
        in_tag    = tag;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [4:0]  tag;
        logic [4:0]  exp; // {less, equal, greater, taken, illegal}
    } vec_t;

    vec_t vecs [11];

    initial begin
        int base;
        int sent;
        int low;
        int mark;
        logic [3:0] pat;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 5'd1,  5'b10010}; // BLT  -1 < 1
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 5'd2,  5'b00100}; // BLTU
        vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 3'b000, 5'd3,  5'b01010}; // BEQ
        vecs[3]  = '{32'h8000_0000, 32'h8000_0000, 3'b001, 5'd4,  5'b01000}; // BNE
        vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 3'b011, 5'd5,  5'b01001}; // illegal
        vecs[5]  = '{32'h0000_0005, 32'hFFFF_FFFF, 3'b101, 5'd6,  5'b00110}; // BGE 5 >= -1
        vecs[6]  = '{32'h0000_0005, 32'hFFFF_FFFF, 3'b111, 5'd7,  5'b10000}; // BGEU
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 5'd8,  5'b10001}; // illegal, signed
        vecs[8]  = '{32'h1234_5678, 32'h1234_5679, 3'b110, 5'd9,  5'b10010}; // low chunk decides
        vecs[9]  = '{32'h2000_0000, 32'h1FFF_FFFF, 3'b100, 5'd10, 5'b00100}; // high chunk decides
        vecs[10] = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 5'd11, 5'b10000}; // BGEU unsigned

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        in_funct3 = 3'b000;
        in_tag    = 5'd0;
        out_ready = 1'b1;

        // ---- reset release ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_less", out_less, 0);
        chk("rst_out_equal", out_equal, 0);
        chk("rst_out_greater", out_greater, 0);
        chk("rst_out_taken", out_taken, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_idle_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // ---- directed compare vectors, back to back ----
        base = obs_q.size();
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].tag);
        end
        idle(8);
        chk("vec_count", obs_q.size() - base, 11);
        for (int i = 0; i < 11 && base + i < obs_q.size(); i++) begin
            chk($sformatf("v%0d_tag", i), obs_q[base+i].tag, vecs[i].tag);
            chk($sformatf("v%0d_flags", i),
                {obs_q[base+i].l, obs_q[base+i].e, obs_q[base+i].g, obs_q[base+i].t, obs_q[base+i].i},
                vecs[i].exp);
            chk($sformatf("v%0d_latency", i), obs_q[base+i].lat, 4);
        end

        // ---- streaming with backpressure 1,0,0,1 ----
        base = obs_q.size();
        sent = 0;
        low  = 0;
        pat  = 4'b1001;
        for (int c = 0; c < 200 && (obs_q.size() - base) < 8; c++) begin
            out_ready = pat[c % 4];
            in_valid  = (sent < 8);
            in_a      = sent;
            in_b      = 32'd3;
            in_funct3 = 3'b000;
            in_tag    = sent[4:0];
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (in_valid && !in_ready) low++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", obs_q.size() - base, 8);
        chk("stream_backpressure_seen", (low > 0), 1);
        for (int i = 0; i < 8 && base + i < obs_q.size(); i++) begin
            chk($sformatf("s%0d_tag", i), obs_q[base+i].tag, i);
            chk($sformatf("s%0d_taken", i), obs_q[base+i].t, (i == 3));
        end
        idle(3);

        // ---- flush ----
        mark = cyc;
        send(32'h1, 32'h2, 3'b100, 5'd10);
        send(32'h3, 32'h2, 3'b100, 5'd11);
        send(32'h5, 32'h5, 3'b000, 5'd12);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_tag    = 5'd9;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        base = obs_q.size();
        send(32'h0000_0010, 32'h0000_0020, 3'b110, 5'd13);
        idle(8);
        chk("flush_tag9_absent", (last_seen[9] < mark), 1);
        chk("flush_tag10_absent", (last_seen[10] < mark), 1);
        chk("flush_tag11_absent", (last_seen[11] < mark), 1);
        chk("flush_tag12_absent", (last_seen[12] < mark), 1);
        chk("post_flush_count", obs_q.size() - base, 1);
        if (obs_q.size() > base) begin
            chk("post_flush_tag", obs_q[base].tag, 13);
            chk("post_flush_taken", obs_q[base].t, 1);
            chk("post_flush_latency", obs_q[base].lat, 4);
        end

        // ---- reset mid-stream ----
        out_ready = 1'b0;
        send(32'h1, 32'h1, 3'b000, 5'd20);
        send(32'h2, 32'h1, 3'b000, 5'd21);
        send(32'h3, 32'h1, 3'b000, 5'd22);
        idle(2);
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_tag", out_tag, 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_tag", out_tag, 0);
        mark = cyc + 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        idle(10);
        chk("reset_tag20_absent", (last_seen[20] < mark), 1);
        chk("reset_tag21_absent", (last_seen[21] < mark), 1);
        chk("reset_tag22_absent", (last_seen[22] < mark), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
